// File: rtl/uart_tx_fifo.sv
// Serial transmitter with configurable frame format (5-9 data bits, parity, 1/2 stop bits),
// a write FIFO in front of it and a hold input that gates the start of each new frame.
module uart_tx_fifo #(
  parameter int Clock    = 50000000,
  parameter int Baud     = 9600,
  parameter int DataBits = 8,
  parameter int Parity   = 0,
  parameter int StopBits = 1,
  parameter int Depth    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         txen,
  input  logic [DataBits-1:0]          data,
  input  logic                         hold,
  output logic                         txd,
  output logic                         cts,
  output logic                         busy,
  output logic [$clog2(Depth+1)-1:0]   level
);

  localparam int Div = (Clock + Baud / 2) / Baud;
  localparam int CW  = $clog2(Div);
  localparam int LW  = $clog2(Depth + 1);
  localparam int PW  = $clog2(Depth);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [3:0]          bit_r;
  logic [DataBits-1:0] shift_r;
  logic                par_r;
  logic                txd_r;
  logic                busy_r;
  logic [DataBits-1:0] mem_r [Depth];
  logic [PW-1:0]       wptr_r;
  logic [PW-1:0]       rptr_r;
  logic [LW-1:0]       count_r;

  logic push_s;
  logic pop_s;
  logic ready_s;
  logic bit_end_s;
  logic cts_s;

  // Parity of the word as popped: odd mode makes the total count of ones odd
  function automatic logic par_bit(input logic [DataBits-1:0] w);
    if (Parity == 1) par_bit = ~^w;
    else             par_bit = ^w;
  endfunction

  assign cts_s = (count_r != LW'(Depth));

  // Write acceptance and frame-start decision (IDLE, or the end of the last stop bit)
  always_comb begin
    push_s    = txen && cts_s;
    ready_s   = (count_r != '0) && !hold;
    bit_end_s = (cnt_r == CW'(Div - 1));
    if (state_r == IDLE) begin
      pop_s = ready_s;
    end else if (state_r == STOP && bit_end_s && bit_r == 4'(StopBits - 1)) begin
      pop_s = ready_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Frame sequencer with bit timer; pop takes priority so back-to-back frames have no gap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      bit_r   <= 4'd0;
      shift_r <= '0;
      par_r   <= 1'b0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      if (state_r == IDLE || bit_end_s) cnt_r <= '0;
      else                              cnt_r <= cnt_r + CW'(1);

      if (pop_s) begin
        shift_r <= mem_r[rptr_r];
        par_r   <= par_bit(mem_r[rptr_r]);
        bit_r   <= 4'd0;
        txd_r   <= 1'b0;
        busy_r  <= 1'b1;
        state_r <= START;
      end else begin
        case (state_r)
          IDLE: begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
          end
          START: begin
            if (bit_end_s) begin
              state_r <= DATA;
              bit_r   <= 4'd0;
              txd_r   <= shift_r[0];
            end
          end
          DATA: begin
            if (bit_end_s) begin
              shift_r <= {1'b0, shift_r[DataBits-1:1]};
              if (bit_r == 4'(DataBits - 1)) begin
                bit_r <= 4'd0;
                if (Parity != 0) begin
                  state_r <= PARITY;
                  txd_r   <= par_r;
                end else begin
                  state_r <= STOP;
                  txd_r   <= 1'b1;
                end
              end else begin
                bit_r <= bit_r + 4'd1;
                txd_r <= shift_r[1];
              end
            end
          end
          PARITY: begin
            if (bit_end_s) begin
              state_r <= STOP;
              bit_r   <= 4'd0;
              txd_r   <= 1'b1;
            end
          end
          STOP: begin
            if (bit_end_s) begin
              if (bit_r == 4'(StopBits - 1)) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
                txd_r   <= 1'b1;
              end else begin
                bit_r <= bit_r + 4'd1;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            txd_r   <= 1'b1;
          end
        endcase
      end
    end
  end

  // Write FIFO storage, wrapping pointers and occupancy count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < Depth; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r] <= data;
        wptr_r        <= wptr_r + PW'(1);
      end
      if (pop_s) rptr_r <= rptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + LW'(1);
        2'b01:   count_r <= count_r - LW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign txd   = txd_r;
  assign busy  = busy_r;
  assign cts   = cts_s;
  assign level = count_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four frame formats driven in parallel, each checked every cycle
// against a frame-list model, plus literal expectations for the directed scenarios.
module tb_uart_tx_fifo;

  localparam int DIV = 10;

  logic       clock, reset, txen, hold;
  logic [7:0] data;
  logic [3:0] txd_w, cts_w, busy_w;
  logic [2:0] lvl_w [4];

  int checks, failures;

  // per-instance format: 8N1, 8O1, 8E1, 5N2
  int db [4] = '{8, 8, 8, 5};
  int pm [4] = '{0, 1, 2, 0};
  int sb [4] = '{1, 1, 1, 2};

  int mq [4][4];
  int mcnt [4];
  int fb [4][16];
  int fn [4];
  int pos [4];

  int tr_txd [4][460];
  int tr_busy [4][460];
  int tr_lvl [4][460];
  logic [7:0] wl [5];

  uart_tx_fifo #(.Clock(1000000), .Baud(100000), .DataBits(8), .Parity(0), .StopBits(1), .Depth(4)) u_8n1 (
    .clock(clock), .reset(reset), .txen(txen), .data(data), .hold(hold),
    .txd(txd_w[0]), .cts(cts_w[0]), .busy(busy_w[0]), .level(lvl_w[0]));
  uart_tx_fifo #(.Clock(1000000), .Baud(100000), .DataBits(8), .Parity(1), .StopBits(1), .Depth(4)) u_8o1 (
    .clock(clock), .reset(reset), .txen(txen), .data(data), .hold(hold),
    .txd(txd_w[1]), .cts(cts_w[1]), .busy(busy_w[1]), .level(lvl_w[1]));
  uart_tx_fifo #(.Clock(1000000), .Baud(100000), .DataBits(8), .Parity(2), .StopBits(1), .Depth(4)) u_8e1 (
    .clock(clock), .reset(reset), .txen(txen), .data(data), .hold(hold),
    .txd(txd_w[2]), .cts(cts_w[2]), .busy(busy_w[2]), .level(lvl_w[2]));
  uart_tx_fifo #(.Clock(1000000), .Baud(100000), .DataBits(5), .Parity(0), .StopBits(2), .Depth(4)) u_5n2 (
    .clock(clock), .reset(reset), .txen(txen), .data(data[4:0]), .hold(hold),
    .txd(txd_w[3]), .cts(cts_w[3]), .busy(busy_w[3]), .level(lvl_w[3]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst%0d actual=%0d required=%0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      pos[i]  = -1;
      fn[i]   = 0;
    end
  endtask

  // One clock edge of the model: queue of words, and the active frame as a list of line bits
  task automatic model_step(input int i);
    int w, ones, n;
    bit push, fend, start;
    push  = txen && (mcnt[i] != 4);
    fend  = (pos[i] >= 0) && (pos[i] == fn[i] * DIV - 1);
    start = (pos[i] < 0 || fend) && (mcnt[i] != 0) && !hold;
    if (start) begin
      w = mq[i][0];
      for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
      mcnt[i]--;
      fb[i][0] = 0;
      ones = 0;
      for (int b = 0; b < db[i]; b++) begin
        fb[i][1+b] = (w >> b) & 1;
        ones += (w >> b) & 1;
      end
      n = 1 + db[i];
      if (pm[i] != 0) begin
        if (pm[i] == 1) fb[i][n] = (ones % 2 == 0) ? 1 : 0;
        else            fb[i][n] = (ones % 2 == 1) ? 1 : 0;
        n++;
      end
      for (int s = 0; s < sb[i]; s++) begin
        fb[i][n] = 1;
        n++;
      end
      fn[i]  = n;
      pos[i] = 0;
    end else if (fend) begin
      pos[i] = -1;
    end else if (pos[i] >= 0) begin
      pos[i]++;
    end
    if (push) begin
      mq[i][mcnt[i]] = int'(data) & ((1 << db[i]) - 1);
      mcnt[i]++;
    end
  endtask

  // Every falling edge: compare all outputs with the model, then advance it by one rising edge
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) model_reset();
      for (int i = 0; i < 4; i++) begin
        chk("txd",   i, int'(txd_w[i]),  (pos[i] < 0) ? 1 : fb[i][pos[i] / DIV]);
        chk("busy",  i, int'(busy_w[i]), (pos[i] >= 0) ? 1 : 0);
        chk("level", i, int'(lvl_w[i]),  mcnt[i]);
        chk("cts",   i, int'(cts_w[i]),  (mcnt[i] != 4) ? 1 : 0);
      end
      if (reset) for (int i = 0; i < 4; i++) model_step(i);
    end
  end

  task automatic burst(input int n);
    @(posedge clock);
    #1;
    for (int k = 0; k < n; k++) begin
      txen = 1'b1;
      data = wl[k];
      @(posedge clock);
      #1;
    end
    txen = 1'b0;
  endtask

  task automatic watch(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        tr_txd[i][t]  = int'(txd_w[i]);
        tr_busy[i][t] = int'(busy_w[i]);
        tr_lvl[i][t]  = int'(lvl_w[i]);
      end
    end
  endtask

  function automatic int sum_busy(input int i, input int a, input int b);
    int s = 0;
    for (int t = a; t <= b; t++) s += tr_busy[i][t];
    return s;
  endfunction

  function automatic int sum_txd(input int i, input int a, input int b);
    int s = 0;
    for (int t = a; t <= b; t++) s += tr_txd[i][t];
    return s;
  endfunction

  function automatic int mid_bits(input int i, input int nb);
    int v = 0;
    for (int j = 0; j < nb; j++) v |= tr_txd[i][5 + DIV * j] << j;
    return v;
  endfunction

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    txen = 1'b0; data = 8'h00; hold = 1'b0; reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd",   i, int'(txd_w[i]),  1);
      chk("rst_busy",  i, int'(busy_w[i]), 0);
      chk("rst_level", i, int'(lvl_w[i]),  0);
      chk("rst_cts",   i, int'(cts_w[i]),  1);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // 0x5A in every format
    wl[0] = 8'h5A;
    burst(1);
    watch(130);
    chk("t1_idle_k",   0, tr_txd[0][0], 1);
    chk("t1_fall_k1",  0, tr_txd[0][1], 0);
    chk("t1_bits",     0, mid_bits(0, 10), 10'b1010110100);
    chk("t1_busy_len", 0, sum_busy(0, 0, 129), 100);
    chk("t1_busy_len", 1, sum_busy(1, 0, 129), 110);
    chk("t1_busy_len", 2, sum_busy(2, 0, 129), 110);
    chk("t1_par_odd",  1, tr_txd[1][95], 1);
    chk("t1_par_even", 2, tr_txd[2][95], 0);

    // 0x15 as a 5-bit, two-stop frame
    wl[0] = 8'h15;
    burst(1);
    watch(130);
    chk("t3_bits",     3, mid_bits(3, 8), 8'b11101010);
    chk("t3_stop_hi",  3, sum_txd(3, 61, 80), 20);
    chk("t3_busy_end", 3, tr_busy[3][80], 1);
    chk("t3_busy_off", 3, tr_busy[3][81], 0);
    chk("t3_busy_len", 3, sum_busy(3, 0, 129), 80);

    // fill under hold, fifth write dropped, then drain back-to-back
    @(posedge clock);
    #1 hold = 1'b1;
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33; wl[3] = 8'h44; wl[4] = 8'h55;
    burst(5);
    chk("t4_full_lvl", 0, int'(lvl_w[0]), 4);
    chk("t4_full_cts", 0, int'(cts_w[0]), 0);
    hold = 1'b0;
    watch(460);
    chk("t4_idle0",   0, tr_busy[0][0], 0);
    chk("t4_busy",    0, sum_busy(0, 1, 400), 400);
    chk("t4_busyoff", 0, tr_busy[0][401], 0);
    chk("t4_stop",    0, tr_txd[0][100], 1);
    chk("t4_nogap",   0, tr_txd[0][101], 0);
    chk("t4_lvl3",    0, tr_lvl[0][1], 3);
    chk("t4_lvl2",    0, tr_lvl[0][101], 2);
    chk("t4_lvl1",    0, tr_lvl[0][201], 1);
    chk("t4_lvl0",    0, tr_lvl[0][301], 0);

    // hold raised mid-frame: frame completes, queue stays
    wl[0] = 8'hA1; wl[1] = 8'hB2; wl[2] = 8'hC3;
    burst(3);
    repeat (30) @(posedge clock);
    #1 hold = 1'b1;
    watch(120);
    for (int i = 0; i < 4; i++) begin
      chk("t5_txd_hi", i, int'(txd_w[i]),  1);
      chk("t5_idle",   i, int'(busy_w[i]), 0);
      chk("t5_lvl",    i, int'(lvl_w[i]),  2);
    end
    @(posedge clock);
    #1 hold = 1'b0;
    @(negedge clock);
    chk("t5_pre_start", 0, int'(txd_w[0]), 1);
    @(negedge clock);
    chk("t5_start",     0, int'(txd_w[0]),  0);
    chk("t5_start_lvl", 0, int'(lvl_w[0]),  1);
    repeat (300) @(negedge clock);

    // reset mid-frame with two words queued
    wl[0] = 8'hC4; wl[1] = 8'hD5; wl[2] = 8'hE6;
    burst(3);
    repeat (30) @(posedge clock);
    #1;
    chk("t6_pre_lvl", 0, int'(lvl_w[0]), 2);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t6_txd",  i, int'(txd_w[i]),  1);
      chk("t6_busy", i, int'(busy_w[i]), 0);
      chk("t6_lvl",  i, int'(lvl_w[i]),  0);
      chk("t6_cts",  i, int'(cts_w[i]),  1);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    watch(150);
    for (int i = 0; i < 4; i++) begin
      chk("t6_no_frame", i, sum_busy(i, 0, 149), 0);
      chk("t6_line_hi",  i, sum_txd(i, 0, 149), 150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
